// File: rtl/fire_sequencer_if.sv
// Bundle of the requester, fire-FIFO and spike-stage signals around fire_sequencer.
// master = the sequencer side; slave = the surrounding neuron array, FIFO and synapse stage.
interface fire_sequencer_if #(
  parameter int unsigned TAGBITS = 6,
  parameter int unsigned NREQ    = 4
);
  logic [NREQ-1:0]         req_valid;
  logic [NREQ*TAGBITS-1:0] req_tag;
  logic [NREQ-1:0]         req_ready;
  logic [NREQ-1:0]         upd_done;

  logic                    fifo_enq;
  logic [TAGBITS-1:0]      fifo_in_tag;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic                    fifo_deq;
  logic [TAGBITS-1:0]      fifo_out_tag;

  logic                    spk_valid;
  logic [TAGBITS-1:0]      spk_tag;
  logic                    spk_ready;

  modport master (
    input  req_valid, req_tag, upd_done, fifo_full, fifo_empty, fifo_out_tag, spk_ready,
    output req_ready, fifo_enq, fifo_in_tag, fifo_deq, spk_valid, spk_tag
  );

  modport slave (
    output req_valid, req_tag, upd_done, fifo_full, fifo_empty, fifo_out_tag, spk_ready,
    input  req_ready, fifo_enq, fifo_in_tag, fifo_deq, spk_valid, spk_tag
  );
endinterface

// File: rtl/fire_sequencer.sv
// Timestep controller: round-robin collects fire tags into the fire FIFO, then drains it to the synapse stage.
// Define FIRE_SEQ_STATS_EN to build the full-stall counter; otherwise stall_cnt reads zero.
module fire_sequencer #(
  parameter int unsigned TAGBITS = 6,
  parameter int unsigned NREQ    = 4
) (
  input  logic             clk,
  input  logic             syn_reset_n,
  input  logic             epoch_start,
  output logic             epoch_done,
  fire_sequencer_if.master bus,
  output logic [TAGBITS:0] epoch_spikes,
  output logic [15:0]      stall_cnt
);
  localparam int unsigned RRW  = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned SPKW = TAGBITS + 1;
  localparam logic [SPKW-1:0] SPK_MAX = SPKW'(1) << TAGBITS;

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_DRAIN, S_DONE} state_t;

  state_t          state, state_next;
  logic [RRW-1:0]  rr;
  logic [RRW-1:0]  gnt_idx, hi_idx, lo_idx;
  logic            hi_hit;
  logic [NREQ-1:0] done_q;
  logic            start_acc;

  // Round-robin pick: lowest valid index at/after rr, else lowest valid index overall.
  always_comb begin
    hi_hit = 1'b0;
    hi_idx = '0;
    lo_idx = '0;
    for (int i = int'(NREQ) - 1; i >= 0; i--) begin
      if (bus.req_valid[i]) begin
        lo_idx = RRW'(i);
        if (i >= int'(rr)) begin
          hi_hit = 1'b1;
          hi_idx = RRW'(i);
        end
      end
    end
    gnt_idx = hi_hit ? hi_idx : lo_idx;
  end

  always_ff @(posedge clk) begin
    if (!syn_reset_n) state <= S_IDLE;
    else              state <= state_next;
  end

  always_comb begin
    state_next       = state;
    start_acc        = 1'b0;
    bus.req_ready    = '0;
    bus.fifo_enq     = 1'b0;
    bus.fifo_in_tag  = bus.req_tag[gnt_idx * TAGBITS +: TAGBITS];
    bus.fifo_deq     = 1'b0;
    bus.spk_valid    = 1'b0;
    bus.spk_tag      = bus.fifo_out_tag;
    case (state)
      S_IDLE: begin
        if (epoch_start) begin
          start_acc  = 1'b1;
          state_next = S_COLLECT;
        end
      end
      S_COLLECT: begin
        bus.fifo_enq  = !bus.fifo_full && (|bus.req_valid);
        bus.req_ready = bus.fifo_enq ? (NREQ'(1) << gnt_idx) : '0;
        // A done arriving this cycle counts; any outstanding request holds the epoch open.
        if ((&(done_q | bus.upd_done)) && !(|bus.req_valid)) state_next = S_DRAIN;
      end
      S_DRAIN: begin
        bus.spk_valid = !bus.fifo_empty;
        bus.fifo_deq  = bus.spk_valid && bus.spk_ready;
        if (bus.fifo_empty) state_next = S_DONE;
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!syn_reset_n) begin
      rr           <= '0;
      done_q       <= '0;
      epoch_done   <= 1'b0;
      epoch_spikes <= '0;
    end else begin
      epoch_done <= (state_next == S_DONE);
      if (start_acc) begin
        done_q       <= '0;
        epoch_spikes <= '0;
      end else if (state == S_COLLECT) begin
        done_q <= done_q | bus.upd_done;
        if (bus.fifo_enq) begin
          rr <= (gnt_idx == RRW'(NREQ - 1)) ? '0 : gnt_idx + RRW'(1);
          if (epoch_spikes != SPK_MAX) epoch_spikes <= epoch_spikes + SPKW'(1);
        end
      end
    end
  end

`ifdef FIRE_SEQ_STATS_EN
  always_ff @(posedge clk) begin
    if (!syn_reset_n || start_acc) begin
      stall_cnt <= '0;
    end else if ((state == S_COLLECT) && bus.fifo_full && (|bus.req_valid)
                 && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`else
  assign stall_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_fire_sequencer.sv
// Randomised scoreboard bench for fire_sequencer: a round-robin interleave model predicts the
// enqueue and drain order; a negedge monitor pops and compares whatever the DUT presents.
`timescale 1ns/1ps
module tb_fire_sequencer;
  localparam int unsigned TB      = 6;
  localparam int unsigned NR      = 4;
  localparam int unsigned MAXL    = 4;
  localparam int unsigned FIFOCAP = 16;

  typedef struct {
    int            idx;
    logic [TB-1:0] tag;
  } enq_t;

  logic          clk = 1'b0;
  logic          syn_reset_n;
  logic          epoch_start;
  logic          epoch_done;
  logic [TB:0]   epoch_spikes;
  logic [15:0]   stall_cnt;

  fire_sequencer_if #(.TAGBITS(TB), .NREQ(NR)) bus ();

  fire_sequencer #(.TAGBITS(TB), .NREQ(NR)) dut (
    .clk          (clk),
    .syn_reset_n  (syn_reset_n),
    .epoch_start  (epoch_start),
    .epoch_done   (epoch_done),
    .bus          (bus),
    .epoch_spikes (epoch_spikes),
    .stall_cnt    (stall_cnt)
  );

  always #5 clk = ~clk;

  // requester tag lists, bench FIFO and scoreboard queues
  logic [TB-1:0] lst [NR][MAXL];
  int            lst_len [NR];
  int            lst_pos [NR];
  logic [TB-1:0] fifo_q [$];
  enq_t          exp_enq [$];
  logic [TB-1:0] exp_spk [$];

  int n_chk = 0, n_pass = 0;
  int done_cnt = 0, deq_cnt = 0, cyc = 0, rr_m = 0;
  int stall_left = 0, rdy_mode = 0, first_enq_cyc = -1, ep_cyc = 0;
  bit mon_en = 0, drain_seen = 0, force_full = 0, sim_done = 0;

  logic [NR-1:0] cap_ready;
  logic          cap_enq, cap_deq;
  logic [TB-1:0] cap_in_tag;
  enq_t          mon_e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual %0h, required %0h", name, act, exp);
  endtask

  // Monitor: sample away from the active edge and pop the scoreboard on DUT activity.
  always @(negedge clk) begin
    cap_ready  = bus.req_ready;
    cap_enq    = bus.fifo_enq;
    cap_in_tag = bus.fifo_in_tag;
    cap_deq    = bus.fifo_deq;
    if (mon_en) begin
      if (epoch_done === 1'b1) done_cnt++;
      if (bus.fifo_enq === 1'b1) begin
        if (first_enq_cyc < 0) first_enq_cyc = cyc;
        chk("enq_while_full", 32'(bus.fifo_full), 32'd0);
        chk("enq_expected", 32'(exp_enq.size() != 0), 32'd1);
        if (exp_enq.size() != 0) begin
          mon_e = exp_enq.pop_front();
          chk("grant_onehot", 32'(bus.req_ready), 32'(1) << mon_e.idx);
          chk("enq_tag", 32'(bus.fifo_in_tag), 32'(mon_e.tag));
        end
      end else begin
        chk("ready_without_enq", 32'(bus.req_ready), 32'd0);
      end
      if (bus.spk_valid === 1'b1) begin
        drain_seen = 1'b1;
        chk("spk_valid_on_empty", 32'(bus.fifo_empty), 32'd0);
        chk("spk_expected", 32'(exp_spk.size() != 0), 32'd1);
        if (exp_spk.size() != 0) begin
          chk("spk_tag", 32'(bus.spk_tag), 32'(exp_spk[0]));
          if (bus.spk_ready) void'(exp_spk.pop_front());
        end
        chk("deq_follows_ready", 32'(bus.fifo_deq), 32'(bus.spk_ready));
      end else begin
        chk("deq_without_valid", 32'(bus.fifo_deq), 32'd0);
      end
    end
  end

  // Drive requester, FIFO-flag and spike-ready inputs from the bench state.
  task automatic drive();
    int rem;
    bus.req_valid = '0;
    bus.req_tag   = '0;
    bus.upd_done  = '0;
    for (int i = 0; i < int'(NR); i++) begin
      rem = lst_len[i] - lst_pos[i];
      bus.req_valid[i] = (rem > 0);
      if (rem > 0) bus.req_tag[i*TB +: TB] = lst[i][lst_pos[i]];
      bus.upd_done[i] = sim_done ? (rem <= 1) : (rem == 0);
    end
    bus.fifo_full    = force_full || (fifo_q.size() >= FIFOCAP);
    bus.fifo_empty   = (fifo_q.size() == 0);
    bus.fifo_out_tag = (fifo_q.size() != 0) ? fifo_q[0] : '0;
    case (rdy_mode)
      0:       bus.spk_ready = 1'b1;
      1:       bus.spk_ready = ((cyc % 4) != 1);
      2:       bus.spk_ready = 1'($urandom_range(0, 1));
      default: bus.spk_ready = 1'b0;
    endcase
  endtask

  // Apply the previous cycle's observed handshakes, as a real requester/FIFO would.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    epoch_start = 1'b0;
    for (int i = 0; i < int'(NR); i++)
      if (cap_ready[i] === 1'b1 && lst_pos[i] < lst_len[i]) lst_pos[i]++;
    if (cap_enq === 1'b1) fifo_q.push_back(cap_in_tag);
    if (cap_deq === 1'b1) begin
      deq_cnt++;
      if (fifo_q.size() != 0) void'(fifo_q.pop_front());
    end
    force_full = (stall_left > 0);
    if (stall_left > 0) stall_left--;
    drive();
  endtask

  task automatic clear_lists();
    for (int i = 0; i < int'(NR); i++) begin
      lst_len[i] = 0;
      lst_pos[i] = 0;
    end
  endtask

  // Reference: grants interleave the non-empty lists round-robin from the current pointer.
  task automatic model_epoch(output int total);
    int   remm [NR];
    int   p;
    enq_t e;
    total = 0;
    for (int i = 0; i < int'(NR); i++) begin
      remm[i] = lst_len[i];
      total += lst_len[i];
    end
    p = rr_m;
    for (int g = 0; g < total; g++) begin
      while (remm[p] == 0) p = (p + 1) % int'(NR);
      e.idx = p;
      e.tag = lst[p][lst_len[p] - remm[p]];
      exp_enq.push_back(e);
      exp_spk.push_back(e.tag);
      remm[p]--;
      p = (p + 1) % int'(NR);
      rr_m = p;
    end
  endtask

  task automatic run_epoch(input int s_cycles, input bit simd, input int rmode, input bit check_min);
    int total, n, start_done, exp_stall;
    bit seen;
    model_epoch(total);
    sim_done      = simd;
    rdy_mode      = rmode;
    stall_left    = s_cycles;
    start_done    = done_cnt;
    deq_cnt       = 0;
    first_enq_cyc = -1;
    ep_cyc        = cyc;
    epoch_start   = 1'b1;
    drive();
    seen = 1'b0;
    n    = 0;
    while (!seen && n < 400) begin
      tick();
      n++;
      seen = (done_cnt != start_done);
    end
    chk("epoch_done_seen", 32'(seen), 32'd1);
    if (check_min) chk("min_epoch_cycles", 32'(n), 32'd4);
    tick();
    tick();
    chk("epoch_done_pulses", 32'(done_cnt - start_done), 32'd1);
    chk("epoch_spikes", 32'(epoch_spikes), 32'((total > (1 << TB)) ? (1 << TB) : total));
`ifdef FIRE_SEQ_STATS_EN
    exp_stall = (total > 0) ? s_cycles : 0;
`else
    exp_stall = 0;
`endif
    chk("stall_cnt", 32'(stall_cnt), 32'(exp_stall));
    chk("deq_count", 32'(deq_cnt), 32'(total));
    chk("enq_left", 32'(exp_enq.size()), 32'd0);
    chk("spk_left", 32'(exp_spk.size()), 32'd0);
  endtask

  initial begin
    int  n, total, done_before;
    syn_reset_n = 1'b0;
    epoch_start = 1'b0;
    clear_lists();
    drive();
    tick();
    tick();
    syn_reset_n = 1'b1;
    mon_en      = 1'b1;
    repeat (5) tick();
    @(negedge clk);
    chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
    chk("rst_fifo_enq", 32'(bus.fifo_enq), 32'd0);
    chk("rst_fifo_deq", 32'(bus.fifo_deq), 32'd0);
    chk("rst_spk_valid", 32'(bus.spk_valid), 32'd0);
    chk("rst_epoch_done", 32'(epoch_done), 32'd0);
    chk("rst_epoch_spikes", 32'(epoch_spikes), 32'd0);
    chk("rst_stall_cnt", 32'(stall_cnt), 32'd0);
    chk("idle_no_done_pulse", 32'(done_cnt), 32'd0);

    // shortest possible timestep
    clear_lists();
    run_epoch(0, 1'b0, 0, 1'b1);

    // fairness: every requester holds two tags
    clear_lists();
    for (int i = 0; i < int'(NR); i++) begin
      lst_len[i] = 2;
      lst[i][0]  = TB'($urandom);
      lst[i][1]  = TB'($urandom);
    end
    run_epoch(0, 1'b0, 0, 1'b0);

    // full stall with only requester 1 pending
    clear_lists();
    lst_len[1] = 1;
    lst[1][0]  = TB'($urandom);
    run_epoch(5, 1'b0, 0, 1'b0);
    chk("grant_after_stall_cycle", 32'(first_enq_cyc - ep_cyc), 32'd6);

    // drain with 1,0,1,1 backpressure; pointer is now 2 so the FIFO fills 05,2A,3F
    clear_lists();
    lst_len[2] = 1; lst[2][0] = 6'h05;
    lst_len[3] = 1; lst[3][0] = 6'h2A;
    lst_len[0] = 1; lst[0][0] = 6'h3F;
    run_epoch(0, 1'b0, 1, 1'b0);

    // last done raised together with the final request
    clear_lists();
    lst_len[3] = 2;
    lst[3][0]  = TB'($urandom);
    lst[3][1]  = TB'($urandom);
    run_epoch(0, 1'b1, 0, 1'b0);

    for (int e = 0; e < 12; e++) begin
      clear_lists();
      for (int i = 0; i < int'(NR); i++) begin
        lst_len[i] = int'($urandom_range(0, 3));
        for (int k = 0; k < int'(MAXL); k++) lst[i][k] = TB'($urandom);
      end
      run_epoch(int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)),
                int'($urandom_range(0, 2)), 1'b0);
    end

    // reset while two tags wait in DRAIN
    clear_lists();
    lst_len[0] = 1; lst[0][0] = TB'($urandom);
    lst_len[2] = 1; lst[2][0] = TB'($urandom);
    model_epoch(total);
    sim_done    = 1'b0;
    rdy_mode    = 3;
    drain_seen  = 1'b0;
    done_before = done_cnt;
    epoch_start = 1'b1;
    drive();
    n = 0;
    while (!drain_seen && n < 100) begin
      tick();
      n++;
    end
    chk("drain_reached", 32'(drain_seen), 32'd1);
    chk("tags_in_fifo", 32'(fifo_q.size()), 32'(total));
    syn_reset_n = 1'b0;
    tick();
    @(negedge clk);
    chk("midrst_spk_valid", 32'(bus.spk_valid), 32'd0);
    chk("midrst_fifo_deq", 32'(bus.fifo_deq), 32'd0);
    chk("midrst_epoch_spikes", 32'(epoch_spikes), 32'd0);
    chk("midrst_stall_cnt", 32'(stall_cnt), 32'd0);
    chk("midrst_no_done", 32'(done_cnt - done_before), 32'd0);
    syn_reset_n = 1'b1;
    fifo_q.delete();
    exp_spk.delete();
    exp_enq.delete();
    rr_m = 0;
    drive();
    tick();

    // recovery after reset: pointer restarts at 0
    clear_lists();
    lst_len[1] = 1; lst[1][0] = TB'($urandom);
    lst_len[3] = 2; lst[3][0] = TB'($urandom); lst[3][1] = TB'($urandom);
    run_epoch(0, 1'b0, 2, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/fire_sequencer.md
# fire_sequencer

Epoch controller and arbiter for the fire FIFO. During COLLECT it round-robin arbitrates fire events from NREQ neuron-update units and enqueues their tags. During DRAIN it dequeues the FIFO into the synapse-update unit over a valid/ready handshake. It sits between the neuron-update array, the fire FIFO and the synapse stage, and it sequences one simulation timestep per `epoch_start`.

## Interface
Parameters:
- `TAGBITS`, 6, neuron tag width (must match the fire FIFO)
- `NREQ`, 4, number of neuron-update requesters (2..16)

Ports:
- `clk`  in  1  clock
- `syn_reset_n`  in  1  reset, synchronous, active-low
- `epoch_start`  in  1  begin one timestep; sampled in IDLE only
- `epoch_done`  out  1  one-cycle pulse when a timestep completes
- `req_valid`  in  NREQ  requester i has a fire tag
- `req_tag`  in  NREQ*TAGBITS  requester i's tag at `[i*TAGBITS +: TAGBITS]`
- `req_ready`  out  NREQ  one-hot grant; tag consumed this cycle
- `upd_done`  in  NREQ  pulse/level: requester i has finished this timestep
- `fifo_enq`  out  1  enqueue strobe to the fire FIFO
- `fifo_in_tag`  out  TAGBITS  tag to the fire FIFO
- `fifo_full`  in  1  fire FIFO full
- `fifo_empty`  in  1  fire FIFO empty
- `fifo_deq`  out  1  dequeue strobe to the fire FIFO
- `fifo_out_tag`  in  TAGBITS  FIFO head tag
- `spk_valid`  out  1  spike tag offered to the synapse stage
- `spk_tag`  out  TAGBITS  spike tag
- `spk_ready`  in  1  synapse stage accepts
- `epoch_spikes`  out  TAGBITS+1  tags enqueued in the current or last timestep
- `stall_cnt`  out  16  full-stall cycles (see Configuration)

## Operation
- The FSM has four states: IDLE, COLLECT, DRAIN, DONE. Reset state is IDLE.
- **IDLE**
  - When `epoch_start` = 1, go to COLLECT.
  - On that transition, clear the done flags, `epoch_spikes` and `stall_cnt`.
  - `epoch_start` is ignored in every other state.
- **COLLECT**
  - Per-requester sticky done flags are set by `upd_done[i]`.
  - Arbitration is round-robin starting at pointer `rr`. The grantee g is the first i at or after `rr`, wrapping, with `req_valid[i]` = 1.
  - `fifo_enq` = (state == COLLECT) & `!fifo_full` & `|req_valid`.
  - `req_ready[g]` = `fifo_enq`, and `fifo_in_tag` = tag of g. Both are combinational.
  - On a grant, `rr` ← (g+1) mod NREQ and `epoch_spikes` increments (saturating at 2^TAGBITS).
  - When `fifo_full` = 1 and a request is pending, there is no grant and requesters hold their tags (stall).
  - Go to DRAIN when all done flags are set, including a done arriving in the same cycle, and `req_valid` = 0.
- **DRAIN**
  - `spk_valid` = `!fifo_empty`, `spk_tag` = `fifo_out_tag`, `fifo_deq` = `spk_valid & spk_ready`.
  - Go to DONE when `fifo_empty` = 1.
  - `fifo_enq` = 0 throughout DRAIN, so enq and deq are never asserted together.
- **DONE**: `epoch_done` = 1 for one cycle, then go to IDLE.
- Requesters must not assert `req_valid` after their `upd_done`. Such a request is granted normally but blocks the move to DRAIN until it is served.

## Timing
- Reset values:
  - FSM in IDLE, `rr` = 0, done flags = 0.
  - `epoch_done` = 0, `epoch_spikes` = 0, `stall_cnt` = 0.
  - All combinational outputs (`req_ready`, `fifo_enq`, `fifo_deq`, `spk_valid`) are 0 in IDLE.
- Enqueue latency is 0: grant and `fifo_enq` occur in the same cycle as `req_valid`. At most one enqueue per cycle.
- `fifo_full` and `fifo_empty` are registered in the FIFO and reflect an enq/deq one cycle later. Strobes always gate on the current flag value.
- Minimum epoch with no spikes and all `upd_done` high in the first COLLECT cycle is 4 cycles: `epoch_start` cycle, COLLECT, DRAIN (empty), DONE pulse.
- Drain throughput is one tag per cycle while `spk_ready` = 1.
- Synchronous reset mid-epoch forces IDLE on the next edge, clearing all of the above. The FIFO contents are not touched; the FIFO has its own reset.

## Configuration
- Macro: `FIRE_SEQ_STATS_EN`.
- **Defined**: `stall_cnt` increments, saturating at 16'hFFFF, on every COLLECT cycle where `fifo_full` = 1 and `|req_valid` = 1. It clears on an accepted `epoch_start` or on reset.
- **Undefined**: the counter is not built and `stall_cnt` is tied to 16'h0000. The port is always present.

## Test plan
- **Reset and idle**: hold `syn_reset_n` = 0 for 2 cycles, then release with no `epoch_start` → all outputs 0 and `epoch_done` never pulses.
- **Round-robin fairness**: NREQ = 4, all `req_valid` = 1 for 8 cycles, FIFO never full → grants in order 0,1,2,3,0,1,2,3 and `epoch_spikes` = 8.
- **Full stall**: `fifo_full` = 1 for 5 cycles with `req_valid` = 4'b0010 → no `fifo_enq`, `req_ready` = 0 throughout, `stall_cnt` = 5 with the macro defined and 0 without. Then drop full → requester 1 is granted on the next cycle.
- **Drain with backpressure**: 3 tags queued (0x05, 0x2A, 0x3F); `spk_ready` toggles 1,0,1,1 → `fifo_deq` pulses exactly 3 times, each tag is presented and held while `spk_ready` = 0, then DONE and one `epoch_done` pulse.
- **Simultaneous done and request**: the last `upd_done` arrives in the same cycle as that requester's final `req_valid` → the tag is enqueued first, DRAIN is entered the next cycle, and `epoch_spikes` counts it.
- **Reset mid-drain**: assert `syn_reset_n` = 0 during DRAIN with 2 tags left → next cycle IDLE, `fifo_deq` = 0, `spk_valid` = 0, `epoch_spikes` = 0.
